// File: rtl/render_pkg.sv
// render_pkg: shared state codes, grid-owner constants and stage indices for the frame sequencer.
package render_pkg;
  localparam logic [2:0] WAIT_IN = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] START   = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
  localparam logic [7:0] GRID_NONE = 8'hFF;
  localparam int STAGE_LEVEL = 0;
  localparam int STAGE_GRID  = 1;
  localparam int STAGE_RAY   = 2;
endpackage

// File: rtl/key_edge.sv
// key_edge: registers key lines and emits registered one-cycle rise pulses.
module key_edge #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] key,
  output logic [W-1:0] rise
);
  logic [W-1:0] key_q, rise_q, rise_d;
  always_comb rise_d = key & ~key_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_q  <= '0;
      rise_q <= '0;
    end else begin
      key_q  <= key;
      rise_q <= rise_d;
    end
  end
  assign rise = rise_q;
endmodule

// File: rtl/render_sequencer.sv
// render_sequencer: captures operands by key press, then runs stages in order with start/done handshakes.
// Optional per-stage watchdog enabled by defining RENDER_SEQ_WATCHDOG_EN.
module render_sequencer import render_pkg::*; #(
  parameter int NUM_INPUTS = 3,
  parameter int NUM_STAGES = 3,
  parameter int IDX_W      = 3,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] key,
  input  logic                  continuous,
  output logic [NUM_INPUTS-1:0] load,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [IDX_W-1:0]      grid_access,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  timeout_err,
  output logic [IDX_W-1:0]      err_stage
);
  localparam logic [IDX_W-1:0] LAST_IN = IDX_W'(NUM_INPUTS - 1);
  localparam logic [IDX_W-1:0] LAST_ST = IDX_W'(NUM_STAGES - 1);
  logic [2:0] state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_INPUTS-1:0] rise;
  logic key_hit, done_hit, wd_hit, abort, owner;

  key_edge #(.W(NUM_INPUTS)) u_key_edge (
    .clock (clock),
    .reset (reset),
    .key   (key),
    .rise  (rise)
  );

  assign key_hit  = |(rise & (NUM_INPUTS'(1) << idx_q));
  assign done_hit = |(stage_done & (NUM_STAGES'(1) << idx_q));

`ifdef RENDER_SEQ_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic terr_q, terr_d, abort_q;
  logic [IDX_W-1:0] estage_q, estage_d;
  always_comb begin
    cnt_d    = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
    wd_hit   = (state_q == WAIT) && !done_hit && (cnt_q == CW'(TIMEOUT - 1));
    terr_d   = terr_q | wd_hit;
    estage_d = wd_hit ? idx_q : estage_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      terr_q   <= 1'b0;
      estage_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
      estage_q <= estage_d;
      abort_q  <= wd_hit;
    end
  end
  // abort_q is only meaningful in DONE, which always directly follows the timeout
  assign abort       = abort_q;
  assign timeout_err = terr_q;
  assign err_stage   = estage_q;
`else
  assign wd_hit      = 1'b0;
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
  assign err_stage   = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_IN;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      WAIT_IN: state_d = key_hit ? LOAD : WAIT_IN;
      LOAD: begin
        state_d = (idx_q == LAST_IN) ? START : WAIT_IN;
        idx_d   = (idx_q == LAST_IN) ? IDX_W'(STAGE_LEVEL) : idx_q + 1'b1;
      end
      START: state_d = WAIT;
      WAIT: begin
        state_d = done_hit ? ((idx_q == LAST_ST) ? DONE : START) : (wd_hit ? DONE : WAIT);
        idx_d   = done_hit ? ((idx_q == LAST_ST) ? '0 : idx_q + 1'b1) : (wd_hit ? '0 : idx_q);
      end
      DONE: state_d = (continuous && !abort) ? START : WAIT_IN;
      default: begin
        state_d = WAIT_IN;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    owner       = (state_q == START) || (state_q == WAIT);
    load        = (state_q == LOAD) ? NUM_INPUTS'(1) << idx_q : '0;
    stage_start = (state_q == START) ? NUM_STAGES'(1) << idx_q : '0;
    grid_access = owner ? idx_q : GRID_NONE[IDX_W-1:0];
    busy        = owner;
    frame_done  = (state_q == DONE);
  end
endmodule

// File: tb/tb_render_sequencer.sv
// tb_render_sequencer: randomized frames with expectations derived from the sequencer's cycle-latency rules.
// Define RENDER_SEQ_WATCHDOG_EN to also exercise the watchdog with TIMEOUT=20.
module tb_render_sequencer;
  import render_pkg::*;
  localparam int NI = 3;
  localparam int NS = 3;
  localparam int IW = 3;
`ifdef RENDER_SEQ_WATCHDOG_EN
  localparam int TO = 20;
`else
  localparam int TO = 65535;
`endif
  localparam logic [IW-1:0] NONE = 3'd7;

  logic clock = 1'b0, reset = 1'b0, continuous = 1'b0;
  logic [NI-1:0] key = '0, load;
  logic [NS-1:0] stage_start, stage_done = '0;
  logic [IW-1:0] grid_access, err_stage;
  logic busy, frame_done, timeout_err;
  logic exp_terr = 1'b0;
  logic [IW-1:0] exp_estage = '0;
  int total = 0, bad = 0;

  render_sequencer #(.NUM_INPUTS(NI), .NUM_STAGES(NS), .IDX_W(IW), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .key         (key),
    .continuous  (continuous),
    .load        (load),
    .stage_start (stage_start),
    .stage_done  (stage_done),
    .grid_access (grid_access),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .err_stage   (err_stage)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (load,start,grid,busy,fd,terr,estage)", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({load, stage_start, grid_access, busy, frame_done, timeout_err, err_stage});
  endfunction

  // one clock cycle with the current inputs; outputs compared mid-cycle
  task automatic cyc(input string tag, input logic [NI-1:0] el, input logic [NS-1:0] es,
                     input logic [IW-1:0] eg, input logic eb, input logic ef);
    @(negedge clock);
    check(tag, outs(), 32'({el, es, eg, eb, ef, exp_terr, exp_estage}));
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input string tag);
    cyc(tag, '0, '0, NONE, 1'b0, 1'b0);
  endtask

  // key rise seen in cycle t=0 must produce load exactly at t=2, once, however long the key is held
  task automatic capture_one(input int i);
    int hold = (i < NI - 1) ? $urandom_range(1, 6) : $urandom_range(1, 3);
    int len  = (hold > 3) ? hold : 3;
    if ($urandom_range(0, 1) == 1) begin
      int j = (i + $urandom_range(1, NI - 1)) % NI;
      key = NI'(1) << j;
      idle("cap_noise");
      key = '0;
    end
    repeat ($urandom_range(0, 2)) idle("cap_gap");
    for (int t = 0; t < len; t++) begin
      key = (t < hold) ? NI'(1) << i : '0;
      cyc("cap", (t == 2) ? NI'(1) << i : '0, '0, NONE, 1'b0, 1'b0);
    end
    key = '0;
  endtask

  task automatic capture_all();
    for (int i = 0; i < NI; i++) capture_one(i);
  endtask

  // done of the active stage rises lat cycles after its start; everything else on stage_done is noise
  task automatic run_stage(input int s);
    int lat = $urandom_range(1, 5);
    logic [NS-1:0] own = NS'(1) << s;
    stage_done = (NS'($urandom) & ~own) | (($urandom_range(0, 1) == 1) ? own : '0);
    continuous = 1'($urandom);
    key = NI'($urandom);
    cyc("start", '0, own, IW'(s), 1'b1, 1'b0);
    for (int w = 1; w <= lat; w++) begin
      stage_done = (NS'($urandom) & ~own) | ((w == lat) ? own : '0);
      continuous = 1'($urandom);
      key = NI'($urandom);
      cyc("wait", '0, '0, IW'(s), 1'b1, 1'b0);
    end
  endtask

  task automatic run_frame(input bit cap, input bit cont);
    if (cap) capture_all();
    for (int s = 0; s < NS; s++) run_stage(s);
    stage_done = NS'($urandom);
    key = '0;
    continuous = cont;
    cyc("done", '0, '0, NONE, 1'b0, 1'b1);
  endtask

  initial begin
    bit cap = 1'b1;
    bit cont;
    #3;
    check("reset_state", outs(), 32'({3'b000, 3'b000, NONE, 1'b0, 1'b0, 1'b0, 3'b000}));
    #9 reset = 1'b1;
    @(posedge clock);
    #1;
    for (int f = 0; f < 12; f++) begin
      cont = (f == 11) ? 1'b0 : 1'($urandom);
      run_frame(cap, cont);
      cap = !cont;
    end
    // asynchronous reset while stage 1 is waiting
    capture_all();
    run_stage(STAGE_LEVEL);
    stage_done = '0;
    key = '0;
    cyc("start1", '0, 3'b010, IW'(STAGE_GRID), 1'b1, 1'b0);
    cyc("wait1", '0, '0, IW'(STAGE_GRID), 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1 check("async_reset", outs(), 32'({3'b000, 3'b000, NONE, 1'b0, 1'b0, 1'b0, 3'b000}));
    @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    key = 3'b010;
    idle("post_rst_k1");
    key = '0;
    repeat (3) idle("post_rst_idle");
    run_frame(1'b1, 1'b0);
`ifdef RENDER_SEQ_WATCHDOG_EN
    capture_all();
    run_stage(STAGE_LEVEL);
    stage_done = '0;
    cyc("wd_start1", '0, 3'b010, IW'(STAGE_GRID), 1'b1, 1'b0);
    for (int w = 1; w <= TO; w++) begin
      stage_done = NS'($urandom) & 3'b101;
      cyc("wd_wait", '0, '0, IW'(STAGE_GRID), 1'b1, 1'b0);
    end
    exp_terr = 1'b1;
    exp_estage = IW'(STAGE_GRID);
    continuous = 1'b1;
    stage_done = '0;
    cyc("wd_done", '0, '0, NONE, 1'b0, 1'b1);
    continuous = 1'b0;
    run_frame(1'b1, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
